// File: rtl/rv_pkg.sv
// rv_pkg: shared widths, register indices and ALU control encoding for the RV core
package rv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA = 5'd1;
  localparam logic [REG_ADDR_W-1:0] REG_SP = 5'd2;
  localparam logic [REG_ADDR_W-1:0] REG_GP = 5'd3;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: read/write port bundle between the datapath (master) and the register file (slave)
interface reg_file_if;
  import rv_pkg::*;
  logic [REG_ADDR_W-1:0] A1;
  logic [REG_ADDR_W-1:0] A2;
  logic [REG_ADDR_W-1:0] A3;
  logic WE3;
  logic [XLEN-1:0] WD3;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic [15:0] wr_count;
  modport master(output A1, A2, A3, WE3, WD3, input RD1, RD2, wr_count);
  modport slave(input A1, A2, A3, WE3, WD3, output RD1, RD2, wr_count);
endinterface

// File: rtl/reg_read_port.sv
// reg_read_port: combinational read with x0 masking; REGFILE_BYPASS_EN adds write-first forwarding
module reg_read_port #(
  parameter int XLEN = 32,
  parameter int NREGS = 32
) (
  input logic [4:0] ra,
  input logic [XLEN-1:0] regs [NREGS],
`ifdef REGFILE_BYPASS_EN
  input logic wr_en,
  input logic [4:0] wa,
  input logic [XLEN-1:0] wd,
`endif
  output logic [XLEN-1:0] rd
);
  import rv_pkg::*;
`ifdef REGFILE_BYPASS_EN
  // x0 check comes first so a forwarded write can never make x0 non-zero
  assign rd = (ra == REG_ZERO) ? '0 : (wr_en && ra == wa) ? wd : regs[ra];
`else
  assign rd = (ra == REG_ZERO) ? '0 : regs[ra];
`endif
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 integer register file, async active-low reset, x0 hardwired to zero.
// Define REGFILE_BYPASS_EN for write-first forwarding on both read ports.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter logic [XLEN-1:0] SP_INIT = 32'h0000_0FFC,
  parameter logic [XLEN-1:0] GP_INIT = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n,
  reg_file_if.slave rf
);
  import rv_pkg::*;
  if (NREGS != 32) begin : g_nregs_chk
    $error("reg_file: NREGS must be 32");
  end
  logic [XLEN-1:0] regs [NREGS];
  logic [15:0] cnt;
  logic wr_en;
  assign wr_en = rf.WE3 && rf.A3 != REG_ZERO;
  assign rf.wr_count = cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      regs[REG_SP] <= SP_INIT;
      regs[REG_GP] <= GP_INIT;
      cnt <= '0;
    end else if (wr_en) begin
      regs[rf.A3] <= rf.WD3;
      cnt <= cnt + 16'd1;
    end
  end
  reg_read_port #(.XLEN(XLEN), .NREGS(NREGS)) u_port_a (
    .ra(rf.A1),
    .regs(regs),
`ifdef REGFILE_BYPASS_EN
    .wr_en(wr_en),
    .wa(rf.A3),
    .wd(rf.WD3),
`endif
    .rd(rf.RD1)
  );
  reg_read_port #(.XLEN(XLEN), .NREGS(NREGS)) u_port_b (
    .ra(rf.A2),
    .regs(regs),
`ifdef REGFILE_BYPASS_EN
    .wr_en(wr_en),
    .wa(rf.A3),
    .wd(rf.WD3),
`endif
    .rd(rf.RD2)
  );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: table-driven directed checks of reg_file plus reset, same-cycle and wrap sequences
module tb_reg_file;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  reg_file_if rf();
  reg_file dut(.clk(clk), .rst_n(rst_n), .rf(rf));
  always #5 clk = ~clk;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic we;
    logic [4:0] a3;
    logic [31:0] wd;
    logic [4:0] a1;
    logic [4:0] a2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    rf.WE3 = we;
    rf.A3 = a3;
    rf.WD3 = wd;
    rf.A1 = a1;
    rf.A2 = a2;
  endtask
  initial begin
    // reads are sampled before the write edge, count after it
    vecs[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 5'd2, 5'd3, 32'h0000_0FFC, 32'h0, 16'd1};
    vecs[1] = '{1'b1, 5'd6, 32'h0000_0007, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0, 16'd2};
    vecs[2] = '{1'b0, 5'd6, 32'h1234_5678, 5'd5, 5'd6, 32'hDEAD_BEEF, 32'h7, 16'd2};
    vecs[3] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF, 16'd2};
    vecs[4] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 16'd2};
    vecs[5] = '{1'b1, 5'd7, 32'h0000_0011, 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd3};
    vecs[6] = '{1'b0, 5'd7, 32'h0, 5'd7, 5'd7, 32'h11, 32'h11, 16'd3};
    vecs[7] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 5'd2, 5'd1, 32'h0000_0FFC, 32'h0, 16'd4};
    vecs[8] = '{1'b1, 5'd2, 32'h0000_1000, 5'd31, 5'd4, 32'hA5A5_A5A5, 32'h0, 16'd5};
    vecs[9] = '{1'b0, 5'd2, 32'h0, 5'd2, 5'd31, 32'h0000_1000, 32'hA5A5_A5A5, 16'd5};
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_wr_count", {16'h0, rf.wr_count}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rf.A1 = 5'(i);
      rf.A2 = 5'(31 - i);
      #1;
      chk($sformatf("reset_rd1_x%0d", i), rf.RD1, (i == 2) ? 32'h0000_0FFC : 32'h0);
      chk($sformatf("reset_rd2_x%0d", 31 - i), rf.RD2, (i == 29) ? 32'h0000_0FFC : 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].we, vecs[v].a3, vecs[v].wd, vecs[v].a1, vecs[v].a2);
      #1;
      chk($sformatf("vec%0d_rd1", v), rf.RD1, vecs[v].rd1);
      chk($sformatf("vec%0d_rd2", v), rf.RD2, vecs[v].rd2);
      @(posedge clk);
      #1 chk($sformatf("vec%0d_cnt", v), {16'h0, rf.wr_count}, {16'h0, vecs[v].cnt});
      @(negedge clk);
    end
    drive(1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
    #1;
    chk("samecyc_rd1", rf.RD1, BYP ? 32'h22 : 32'h11);
    chk("samecyc_rd2", rf.RD2, BYP ? 32'h22 : 32'h11);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    #1 chk("samecyc_next_rd1", rf.RD1, 32'h22);
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h55, 5'd9, 5'd7);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_x9", rf.RD1, 32'h0);
    chk("rst_mid_x7", rf.RD2, 32'h0);
    chk("rst_mid_cnt", {16'h0, rf.wr_count}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_x9", rf.RD1, 32'h55);
    chk("post_rst_cnt", {16'h0, rf.wr_count}, 32'h1);
    @(negedge clk) rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 5'd1, 32'(i), 5'd1, 5'd0);
      @(negedge clk);
    end
    drive(1'b0, 5'd1, 32'h0, 5'd1, 5'd0);
    #1;
    chk("wrap_pre_cnt", {16'h0, rf.wr_count}, 32'h0000_FFFF);
    chk("wrap_pre_x1", rf.RD1, 32'd65534);
    drive(1'b1, 5'd1, 32'h0000_CAFE, 5'd1, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd1, 32'h0, 5'd1, 5'd0);
    #1;
    chk("wrap_cnt", {16'h0, rf.wr_count}, 32'h0);
    chk("wrap_x1", rf.RD1, 32'h0000_CAFE);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
